// File: rtl/operand_fetch.sv
// Register-read stage: decodes ALU-class instructions, reads the 31-word register file
// (R31 reads zero) and holds one registered operand entry. Optional macro: OPERAND_BYPASS_EN.
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  fn,
  output logic [4:0]  rc,
  output logic        illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam logic [1:0] FORM_REG = 2'b10;
  localparam logic [1:0] FORM_LIT = 2'b11;
  localparam logic       ST_EMPTY = 1'b0;
  localparam logic       ST_FULL  = 1'b1;

  logic [31:0] rf_q [0:30];
  logic [31:0] rf_d [0:30];
  logic [30:0] wr_sel;

  logic        state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  fn_q, fn_d;
  logic [4:0]  rc_q, rc_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  opcode;
  logic [4:0]  ra_idx;
  logic [4:0]  rb_idx;
  logic        accept;
  logic        is_reg_form;
  logic        is_lit_form;
  logic        load;
  logic [31:0] ra_val;
  logic [31:0] rb_val;
  logic [31:0] lit_sext;
  logic        a_fwd;
  logic        b_fwd;

  assign opcode      = instr[31:26];
  assign ra_idx      = instr[20:16];
  assign rb_idx      = instr[15:11];
  assign lit_sext    = {{16{instr[15]}}, instr[15:0]};
  assign is_reg_form = (opcode[5:4] == FORM_REG);
  assign is_lit_form = (opcode[5:4] == FORM_LIT);

  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && (is_reg_form || is_lit_form);

  // One write-select line per storage word; index ZERO_REG has no word, so its writes vanish.
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_wsel
      assign wr_sel[gi] = wb_en && (wb_addr == 5'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      rf_d[i] = wr_sel[i] ? wb_data : rf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 31; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  always_comb begin
    ra_val = '0;
    rb_val = '0;
    if (ra_idx != ZERO_REG) ra_val = rf_q[ra_idx];
    if (rb_idx != ZERO_REG) rb_val = rf_q[rb_idx];
  end

`ifdef OPERAND_BYPASS_EN
  // Write-through: a same-cycle writeback to a source register wins over the stored word.
  assign a_fwd = wb_en && (wb_addr == ra_idx) && (ra_idx != ZERO_REG);
  assign b_fwd = wb_en && (wb_addr == rb_idx) && (rb_idx != ZERO_REG);
`else
  assign a_fwd = 1'b0;
  assign b_fwd = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fn_d      = fn_q;
    rc_d      = rc_q;
    illegal_d = accept && !(is_reg_form || is_lit_form);

    if (load) begin
      state_d = ST_FULL;
      a_d     = a_fwd ? wb_data : ra_val;
      if (is_lit_form) begin
        b_d = lit_sext;
      end else begin
        b_d = b_fwd ? wb_data : rb_val;
      end
      fn_d = opcode;
      rc_d = instr[25:21];
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      fn_q      <= '0;
      rc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      fn_q      <= fn_d;
      rc_q      <= rc_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign a         = a_q;
  assign b         = b_q;
  assign fn        = fn_q;
  assign rc        = rc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed steps plus random traffic against a register/entry model.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  fn;
  logic [4:0]  rc;
  logic        illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [0:31];
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [5:0]  m_fn;
  logic [4:0]  m_rc;
  logic        m_ill;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .fn(fn), .rc(rc), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc_i,
                                     input logic [4:0] ra_i, input logic [4:0] rb_i);
    return {op, rc_i, ra_i, rb_i, 11'd0};
  endfunction

  function automatic logic [31:0] mkl(input logic [5:0] op, input logic [4:0] rc_i,
                                      input logic [4:0] ra_i, input logic [15:0] lit);
    return {op, rc_i, ra_i, lit};
  endfunction

  // Value an operand read sees this cycle: R31 is zero, writeback visible only with bypass.
  function automatic logic [31:0] rd(input logic [4:0] idx);
    if (idx == 5'd31) return 32'd0;
`ifdef OPERAND_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_fn = 6'd0; m_rc = 5'd0; m_ill = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle();
    logic       acc;
    logic [5:0] op;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    acc = in_valid && (!m_valid || out_ready);
    op  = instr[31:26];
    m_ill = acc && !op[5];
    if (acc && op[5]) begin
      m_valid = 1'b1;
      m_a  = rd(instr[20:16]);
      m_b  = op[4] ? {{16{instr[15]}}, instr[15:0]} : rd(instr[15:11]);
      m_fn = op;
      m_rc = instr[25:21];
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("illegal", 32'(illegal), 32'(m_ill));
    if (m_valid) begin
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("fn", 32'(fn), 32'(m_fn));
      chk("rc", 32'(rc), 32'(m_rc));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = v; instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    cycle();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; instr = 32'd0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_fn", 32'(fn), 32'd0);
    chk("rst_rc", 32'(rc), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Register form
    drive(0, 32'd0, 1, 1, 5'd1, 32'd5);
    drive(0, 32'd0, 1, 1, 5'd2, 32'd7);
    drive(1, mk(6'h20, 5'd3, 5'd1, 5'd2), 1, 0, 5'd0, 32'd0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", a, 32'd5);
    chk("add_b", b, 32'd7);
    chk("add_fn", 32'(fn), 32'h20);
    chk("add_rc", 32'(rc), 32'd3);

    // Literal form, back-to-back
    drive(1, mkl(6'h30, 5'd4, 5'd1, 16'hFFFE), 1, 0, 5'd0, 32'd0);
    chk("lit_b", b, 32'hFFFF_FFFE);
    chk("lit_a", a, 32'd5);

    // R31 ignores writes
    drive(0, 32'd0, 1, 1, 5'd31, 32'h1234);
    drive(1, mk(6'h20, 5'd5, 5'd31, 5'd31), 1, 0, 5'd0, 32'd0);
    chk("zero_a", a, 32'd0);
    chk("zero_b", b, 32'd0);

    // Stall: entry held, writes to ra do not leak into it
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(6'h21, 5'd6, 5'd1, 5'd2), 0, 1, 5'd1, 32'h99 + 32'(i));
      chk("hold_a", a, 32'd0);
      chk("hold_rc", 32'(rc), 32'd5);
    end
    drive(1, mk(6'h21, 5'd6, 5'd1, 5'd2), 1, 0, 5'd0, 32'd0);
    chk("release_a", a, 32'h9C);
    chk("release_rc", 32'(rc), 32'd6);

    // Same-cycle write and read of R4
    drive(1, mk(6'h20, 5'd7, 5'd4, 5'd2), 1, 1, 5'd4, 32'hDEAD_BEEF);
`ifdef OPERAND_BYPASS_EN
    chk("hazard_a", a, 32'hDEAD_BEEF);
`else
    chk("hazard_a", a, 32'd0);
`endif
    drive(1, mk(6'h20, 5'd7, 5'd4, 5'd2), 1, 0, 5'd0, 32'd0);
    chk("after_write_a", a, 32'hDEAD_BEEF);

    // Illegal opcode
    drive(1, mk(6'h01, 5'd8, 5'd1, 5'd2), 1, 0, 5'd0, 32'd0);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_no_entry", 32'(out_valid), 32'd0);
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
    chk("illegal_drop", 32'(illegal), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    // Asynchronous reset while FULL
    drive(1, mk(6'h20, 5'd2, 5'd1, 5'd2), 1, 1, 5'd1, 32'h55);
    drive(0, 32'd0, 0, 0, 5'd0, 32'd0);
    chk("pre_reset_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_a", a, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, mk(6'h20, 5'd3, 5'd1, 5'd1), 1, 0, 5'd0, 32'd0);
    chk("post_rst_r1", a, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
